// File: rtl/aes_inv_shift_rows_serial.sv
// rtl/aes_inv_shift_rows_serial.sv - byte-serial AES InvShiftRows stage
//
// Collects one 16-byte AES state in column-major order (byte k = row k%4,
// column k/4) and replays it column-major with out[r][c] = in[r][(c-r) mod 4].
// Row 0 passes through unshifted.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous flush; drops partial/buffered state, keeps bytes
//   in_valid_i   input byte valid
//   in_ready_o   unit can accept an input byte
//   in_data_i    input byte, column-major order
//   out_valid_o  output byte valid
//   out_ready_i  downstream accepts the output byte
//   out_data_o   inverse-shifted byte, column-major order
//   out_last_o   high with the 16th output byte of a state
//
// Build option AES_INV_SR_PINGPONG_EN: two buffer banks so one state fills
// while the previous one drains, sustaining 1 byte/cycle. Without it a
// single buffer alternates between FILL and DRAIN.
module aes_inv_shift_rows_serial #(
   parameter int ByteW = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [ByteW-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ByteW-1:0] out_data_o,
   output logic             out_last_o
);

   logic [3:0] wr_cnt_q, rd_cnt_q;
   logic       in_fire, out_fire;
   logic [1:0] wr_row, wr_col, rd_row, rd_col, src_col;

   // clear_i wins over both handshakes: the byte is neither stored nor consumed
   assign in_fire  = in_valid_i  & in_ready_o  & ~clear_i;
   assign out_fire = out_valid_o & out_ready_i & ~clear_i;

   assign wr_row  = wr_cnt_q[1:0];
   assign wr_col  = wr_cnt_q[3:2];
   assign rd_row  = rd_cnt_q[1:0];
   assign rd_col  = rd_cnt_q[3:2];
   // inverse shift: row r is rotated right by r, 2-bit wrap does the mod 4
   assign src_col = rd_col - rd_row;

   // counters wrap naturally at 16
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_cnt_q <= 4'd0;
         rd_cnt_q <= 4'd0;
      end else if (clear_i) begin
         wr_cnt_q <= 4'd0;
         rd_cnt_q <= 4'd0;
      end else begin
         if (in_fire)  wr_cnt_q <= wr_cnt_q + 4'd1;
         if (out_fire) rd_cnt_q <= rd_cnt_q + 4'd1;
      end
   end

`ifdef AES_INV_SR_PINGPONG_EN

   logic [ByteW-1:0] mem_q [2][4][4];
   logic [1:0]       full_q;
   logic             wr_bank_q, rd_bank_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else if (clear_i) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         // a bank being written is never full and the one being read always
         // is, so a same-cycle fill and drain always touch different bits
         if (in_fire && wr_cnt_q == 4'd15) begin
            full_q[wr_bank_q] <= 1'b1;
            wr_bank_q         <= ~wr_bank_q;
         end
         if (out_fire && rd_cnt_q == 4'd15) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  mem_q[b][r][c] <= '0;
      end else if (in_fire) begin
         mem_q[wr_bank_q][wr_row][wr_col] <= in_data_i;
      end
   end

   always_comb begin
      in_ready_o  = ~full_q[wr_bank_q];
      out_valid_o = full_q[rd_bank_q];
      out_last_o  = full_q[rd_bank_q] && (rd_cnt_q == 4'd15);
      out_data_o  = mem_q[rd_bank_q][rd_row][src_col];
   end

`else

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [ByteW-1:0] mem_q [4][4];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= FILL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = FILL;
      end else begin
         case (state_q)
            FILL:  if (in_fire && wr_cnt_q == 4'd15)  state_d = DRAIN;
            DRAIN: if (out_fire && rd_cnt_q == 4'd15) state_d = FILL;
         endcase
      end
   end

   always_comb begin
      in_ready_o  = (state_q == FILL);
      out_valid_o = (state_q == DRAIN);
      out_last_o  = (state_q == DRAIN) && (rd_cnt_q == 4'd15);
      out_data_o  = mem_q[rd_row][src_col];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               mem_q[r][c] <= '0;
      end else if (in_fire) begin
         mem_q[wr_row][wr_col] <= in_data_i;
      end
   end

`endif

endmodule

// File: tb/tb_aes_inv_shift_rows_serial.sv
// tb/tb_aes_inv_shift_rows_serial.sv - bench for aes_inv_shift_rows_serial
module tb_aes_inv_shift_rows_serial;

   localparam int ByteW = 8;
   // 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, first byte in the LSBs
   localparam logic [127:0] SEQ_EXP = 128'h03_06_09_0C_0F_02_05_08_0B_0E_01_04_07_0A_0D_00;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             clear_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [ByteW-1:0] in_data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [ByteW-1:0] out_data_o;
   logic             out_last_o;

   int n_checks = 0;
   int n_errors = 0;

   aes_inv_shift_rows_serial #(.ByteW(ByteW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // state byte k = row k%4, column k/4, stored at bits [8k +: 8]
   function automatic logic [127:0] inv_sr(input logic [127:0] s);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) begin
         int r, c;
         r = k % 4;
         c = k / 4;
         o[8*k +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
      end
      return o;
   endfunction

   function automatic logic [127:0] fwd_sr(input logic [127:0] s);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) begin
         int r, c;
         r = k % 4;
         c = k / 4;
         o[8*k +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
      end
      return o;
   endfunction

   function automatic logic [127:0] rand_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] incr_state();
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = 8'(k);
      return o;
   endfunction

   // all tasks start and end at a falling edge
   task automatic push_byte(input logic [7:0] d);
      int t = 0;
      in_valid_i = 1'b1;
      in_data_i  = d;
      while (!in_ready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      if (!in_ready_o) check("in_ready_timeout", 0, 1);
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask

   task automatic push_state(input logic [127:0] s);
      for (int k = 0; k < 16; k++) push_byte(s[8*k +: 8]);
   endtask

   task automatic pop_byte(output logic [7:0] d, output logic l);
      int t = 0;
      out_ready_i = 1'b1;
      while (!out_valid_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      if (!out_valid_o) check("out_valid_timeout", 0, 1);
      d = out_data_o;
      l = out_last_o;
      @(negedge clk_i);
      out_ready_i = 1'b0;
   endtask

   task automatic pop_state(output logic [127:0] s, output logic [15:0] lasts);
      for (int k = 0; k < 16; k++) pop_byte(s[8*k +: 8], lasts[k]);
   endtask

   logic [127:0] got, st;
   logic [15:0]  lasts;

   initial begin
      rst_i       = 1'b1;
      clear_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_in_ready", in_ready_o, 1);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_last", out_last_o, 0);
      check("rst_out_data", out_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // directed 0x00..0x0F with latency check
      for (int k = 0; k < 15; k++) push_byte(8'(k));
      check("lat_pre", out_valid_o, 0);
      push_byte(8'h0F);
      check("lat_post", out_valid_o, 1);
`ifndef AES_INV_SR_PINGPONG_EN
      check("drain_in_ready", in_ready_o, 0);
`endif
      pop_state(got, lasts);
      check("seq_const", got, SEQ_EXP);
      check("seq_model", got, inv_sr(incr_state()));
      check("seq_last", lasts, 16'h8000);

      // round trip through forward ShiftRows
      for (int i = 0; i < 1000; i++) begin
         st = rand_state();
         push_state(fwd_sr(st));
         pop_state(got, lasts);
         check("roundtrip", got, st);
         if (i < 4) check("roundtrip_last", lasts, 16'h8000);
      end

      // backpressure at rd_cnt=6
      push_state(incr_state());
      for (int k = 0; k < 6; k++) pop_byte(got[8*k +: 8], lasts[k]);
      for (int i = 0; i < 5; i++) begin
         check("bp_data", out_data_o, SEQ_EXP[55:48]);
         check("bp_valid", out_valid_o, 1);
`ifndef AES_INV_SR_PINGPONG_EN
         check("bp_in_ready", in_ready_o, 0);
`endif
         @(negedge clk_i);
      end
      for (int k = 6; k < 16; k++) pop_byte(got[8*k +: 8], lasts[k]);
      check("bp_seq", got, SEQ_EXP);
      check("bp_last", lasts, 16'h8000);

      // clear during FILL after 9 bytes; the clear-cycle byte is dropped
      st = rand_state();
      for (int k = 0; k < 9; k++) push_byte(st[8*k +: 8]);
      clear_i    = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 8'hAA;
      @(negedge clk_i);
      clear_i    = 1'b0;
      in_valid_i = 1'b0;
      check("clrf_in_ready", in_ready_o, 1);
      check("clrf_out_valid", out_valid_o, 0);
      push_state(incr_state());
      pop_state(got, lasts);
      check("clrf_seq", got, SEQ_EXP);
      check("clrf_last", lasts, 16'h8000);

      // clear during DRAIN; the clear-cycle output is not consumed
      push_state(rand_state());
      for (int k = 0; k < 3; k++) pop_byte(got[8*k +: 8], lasts[k]);
      clear_i     = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      clear_i     = 1'b0;
      out_ready_i = 1'b0;
      check("clrd_out_valid", out_valid_o, 0);
      check("clrd_in_ready", in_ready_o, 1);
      push_state(incr_state());
      pop_state(got, lasts);
      check("clrd_seq", got, SEQ_EXP);
      check("clrd_last", lasts, 16'h8000);

      // asynchronous reset mid-DRAIN, on the last byte, between clock edges
      push_state(rand_state());
      for (int k = 0; k < 15; k++) pop_byte(got[8*k +: 8], lasts[k]);
      check("arst_last_pre", out_last_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_in_ready", in_ready_o, 1);
      check("arst_out_valid", out_valid_o, 0);
      check("arst_out_last", out_last_o, 0);
      check("arst_out_data", out_data_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      st = rand_state();
      push_state(st);
      pop_state(got, lasts);
      check("arst_after", got, inv_sr(st));
      check("arst_after_last", lasts, 16'h8000);

`ifdef AES_INV_SR_PINGPONG_EN
      begin
         logic [127:0] pp_in [4];
         logic [7:0]   outs [$];
         int in_idx, stall, first_cyc, last_cyc;
         in_idx    = 0;
         stall     = 0;
         first_cyc = -1;
         last_cyc  = -1;
         for (int s = 0; s < 4; s++) pp_in[s] = rand_state();
         out_ready_i = 1'b1;
         for (int cyc = 0; cyc < 200 && outs.size() < 64; cyc++) begin
            in_valid_i = (in_idx < 64);
            in_data_i  = (in_idx < 64) ? pp_in[in_idx / 16][8*(in_idx % 16) +: 8] : 8'h00;
            #1;
            if (in_valid_i && !in_ready_o) stall++;
            if (in_valid_i && in_ready_o) in_idx++;
            if (out_valid_o) begin
               outs.push_back(out_data_o);
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
            end
            @(negedge clk_i);
         end
         in_valid_i  = 1'b0;
         out_ready_i = 1'b0;
         check("pp_stall", stall, 0);
         check("pp_count", outs.size(), 64);
         check("pp_first", first_cyc, 16);
         check("pp_span", last_cyc - first_cyc, 63);
         for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 16; k++)
               got[8*k +: 8] = (16*s + k < outs.size()) ? outs[16*s + k] : 8'h00;
            check("pp_state", got, inv_sr(pp_in[s]));
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
